// File: rtl/cpu_parameters.sv
// Shared CPU-wide parameters and writeback types: datapath width, the
// writeback holding-entry layout and the writeback source selector.
package cpu_parameters;

  localparam int xlen = 32;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic [xlen-1:0] data;
    logic            target_valid;
    logic [xlen-1:0] target;
  } wb_entry_t;

  // Branch/jump targets are halfword aligned; bit 0 is never a valid PC bit.
  function automatic logic [xlen-1:0] align_pc(input logic [xlen-1:0] pc);
    return {pc[xlen-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/writeback_if.sv
// Bundle of all writeback-stage signals except clock and reset: the two
// result streams in, and the register-file / release / redirect side out.
interface writeback_if #(
  parameter int XLEN  = cpu_parameters::xlen,
  parameter int CNT_W = 64
);

  // Handshake: a source transfers in any cycle where src_valid and src_ok
  // are both 1 at the rising edge; src_ok never depends on src_valid, and
  // a source holding valid=1 with ok=0 simply retries next cycle.
  logic            alu_valid;
  logic [XLEN-1:0] alu_result;
  logic [4:0]      alu_rd;
  logic            alu_target_valid;
  logic [XLEN-1:0] alu_target;
  logic            alu_ok;

  logic            lsu_valid;
  logic [XLEN-1:0] lsu_result;
  logic [4:0]      lsu_rd;
  logic            lsu_ok;

  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  logic            rel_valid;
  logic [4:0]      rel_rd;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;

  logic [CNT_W-1:0] retired;

  // Producer side: the execution units (or a testbench standing in for them).
  modport master (
    output alu_valid, alu_result, alu_rd, alu_target_valid, alu_target,
    output lsu_valid, lsu_result, lsu_rd,
    input  alu_ok, lsu_ok,
    input  rf_we, rf_waddr, rf_wdata,
    input  rel_valid, rel_rd,
    input  redirect_valid, redirect_pc, flush,
    input  retired
  );

  // Consumer side: the writeback stage itself.
  modport slave (
    input  alu_valid, alu_result, alu_rd, alu_target_valid, alu_target,
    input  lsu_valid, lsu_result, lsu_rd,
    output alu_ok, lsu_ok,
    output rf_we, rf_waddr, rf_wdata,
    output rel_valid, rel_rd,
    output redirect_valid, redirect_pc, flush,
    output retired
  );

endinterface

// File: rtl/writeback_rr_arbiter2.sv
// Two-way round-robin arbiter between the ALU and LSU holding entries.
// Uncontested requests win outright; contested ones go to the source not granted last.
module writeback_rr_arbiter2
  import cpu_parameters::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_alu,
  input  logic req_lsu,
  output logic grant_alu,
  output logic grant_lsu
);

  wb_src_e last_grant;

  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    if (req_alu && req_lsu) begin
      if (last_grant == WB_ALU) begin
        grant_lsu = 1'b1;
      end else begin
        grant_alu = 1'b1;
      end
    end else begin
      grant_alu = req_alu;
      grant_lsu = req_lsu;
    end
  end

  // Every grant, contested or not, moves the priority pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= WB_ALU;
    end else if (grant_alu) begin
      last_grant <= WB_ALU;
    end else if (grant_lsu) begin
      last_grant <= WB_LSU;
    end
  end

endmodule

// File: rtl/writeback.sv
// Writeback stage: one holding entry per result source, one commit per cycle
// to the register file, scoreboard release, and redirect/flush on taken jumps.
module writeback
  import cpu_parameters::*;
#(
  parameter int XLEN  = xlen,
  parameter int CNT_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  writeback_if.slave   bus
);

  wb_entry_t alu_q;
  wb_entry_t lsu_q;
  wb_entry_t commit_e;

  logic             redirect_valid_q;
  logic             flush_q;
  logic [XLEN-1:0]  redirect_pc_q;
  logic [CNT_W-1:0] retired_q;

  logic blocked;
  logic grant_alu;
  logic grant_lsu;
  logic commit_fire;
  logic take_redirect;
  logic alu_ok_w;
  logic lsu_ok_w;
  logic alu_acc;
  logic lsu_acc;

  // Nothing commits or is accepted during reset or during the flush cycle.
  assign blocked = rst || flush_q;

  writeback_rr_arbiter2 rr_arbiter2 (
    .clk       (clk),
    .rst       (rst),
    .req_alu   (alu_q.valid && !blocked),
    .req_lsu   (lsu_q.valid && !blocked),
    .grant_alu (grant_alu),
    .grant_lsu (grant_lsu)
  );

  // With no grant the mux rests on the ALU entry, which cannot change while
  // nothing is valid, so the write-port data/address stay stable when idle.
  always_comb begin
    commit_e      = grant_lsu ? lsu_q : alu_q;
    commit_fire   = commit_e.valid && !blocked;
    take_redirect = commit_fire && grant_alu && commit_e.target_valid;
    alu_ok_w      = !blocked && (!alu_q.valid || grant_alu);
    lsu_ok_w      = !blocked && (!lsu_q.valid || grant_lsu);
    alu_acc       = bus.alu_valid && alu_ok_w;
    lsu_acc       = bus.lsu_valid && lsu_ok_w;
  end

  assign bus.alu_ok         = alu_ok_w;
  assign bus.lsu_ok         = lsu_ok_w;
  assign bus.rf_we          = commit_fire && (commit_e.rd != 5'd0);
  assign bus.rf_waddr       = commit_e.rd;
  assign bus.rf_wdata       = commit_e.data;
  assign bus.rel_valid      = commit_fire;
  assign bus.rel_rd         = commit_e.rd;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = flush_q;
  assign bus.retired        = retired_q;

  // Flush drops everything still held: any entry present then is younger
  // than the jump that redirected, so it must neither write nor release.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q <= '0;
      lsu_q <= '0;
    end else if (flush_q) begin
      alu_q.valid <= 1'b0;
      lsu_q.valid <= 1'b0;
    end else begin
      if (alu_acc) begin
        alu_q.valid        <= 1'b1;
        alu_q.rd           <= bus.alu_rd;
        alu_q.data         <= bus.alu_result;
        alu_q.target_valid <= bus.alu_target_valid;
        alu_q.target       <= bus.alu_target;
      end else if (grant_alu) begin
        alu_q.valid <= 1'b0;
      end

      if (lsu_acc) begin
        lsu_q.valid        <= 1'b1;
        lsu_q.rd           <= bus.lsu_rd;
        lsu_q.data         <= bus.lsu_result;
        lsu_q.target_valid <= 1'b0;
        lsu_q.target       <= '0;
      end else if (grant_lsu) begin
        lsu_q.valid <= 1'b0;
      end
    end
  end

  // Redirect and flush are a one-cycle pulse following the jump's commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= take_redirect;
      flush_q          <= take_redirect;
      if (take_redirect) begin
        redirect_pc_q <= align_pc(commit_e.target);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else if (commit_fire) begin
      retired_q <= retired_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_writeback.sv
// Directed bench for the writeback stage: commits are predicted into a queue
// as stimulus is driven and compared when rel_valid shows up.
module tb_writeback;

  localparam int XLEN  = 32;
  localparam int CNT_W = 64;
  localparam int W     = 1 + 5 + 5 + XLEN;

  logic clk;
  logic rst;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];

  writeback_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  writeback #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- check / driver tasks ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid        = 1'b0;
    bus.alu_result       = '0;
    bus.alu_rd           = '0;
    bus.alu_target_valid = 1'b0;
    bus.alu_target       = '0;
    bus.lsu_valid        = 1'b0;
    bus.lsu_result       = '0;
    bus.lsu_rd           = '0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [XLEN-1:0] data,
                           input logic tv, input logic [XLEN-1:0] tgt);
    bus.alu_valid        = 1'b1;
    bus.alu_rd           = rd;
    bus.alu_result       = data;
    bus.alu_target_valid = tv;
    bus.alu_target       = tgt;
  endtask

  task automatic drive_lsu(input logic [4:0] rd, input logic [XLEN-1:0] data);
    bus.lsu_valid  = 1'b1;
    bus.lsu_rd     = rd;
    bus.lsu_result = data;
  endtask

  task automatic expect_commit(input logic [4:0] rd, input logic [XLEN-1:0] data);
    exp_q.push_back({(rd != 5'd0), rd, rd, data});
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (bus.rel_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_commit", {32'd0, 27'd0, bus.rel_rd}, 64'hDEAD);
      end else begin
        check("commit", {21'd0, bus.rf_we, bus.rel_rd, bus.rf_waddr, bus.rf_wdata},
              {21'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [4:0]      rd_r;
    logic [XLEN-1:0] data_r;

    rst = 1'b1;
    idle_inputs();
    tick();
    tick();

    // reset state
    @(negedge clk);
    check("rst_rf_we", bus.rf_we, 0);
    check("rst_rel_valid", bus.rel_valid, 0);
    check("rst_alu_ok", bus.alu_ok, 0);
    check("rst_lsu_ok", bus.lsu_ok, 0);
    check("rst_retired", bus.retired, 0);
    check("rst_flush", bus.flush, 0);
    check("rst_redirect_valid", bus.redirect_valid, 0);
    check("rst_redirect_pc", bus.redirect_pc, 0);
    tick();
    rst = 1'b0;

    // single ALU result, first accept right after reset release
    drive_alu(5'd5, 32'h1234, 1'b0, '0);
    expect_commit(5'd5, 32'h1234);
    @(negedge clk);
    check("first_accept_alu_ok", bus.alu_ok, 1);
    check("before_commit_rf_we", bus.rf_we, 0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("single_rf_we", bus.rf_we, 1);
    tick();
    @(negedge clk);
    check("single_retired", bus.retired, 1);
    check("single_idle_rel", bus.rel_valid, 0);
    tick();

    // contested grant from reset: LSU first, ALU stalls one cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_alu(5'd3, 32'h33, 1'b0, '0);
    drive_lsu(5'd7, 32'h77);
    expect_commit(5'd7, 32'h77);
    expect_commit(5'd3, 32'h33);
    @(negedge clk);
    check("contest_alu_ok_in", bus.alu_ok, 1);
    check("contest_lsu_ok_in", bus.lsu_ok, 1);
    tick();
    idle_inputs();
    @(negedge clk);
    check("contest_lsu_first", bus.rel_rd, 7);
    check("contest_alu_stall", bus.alu_ok, 0);
    check("contest_lsu_ok", bus.lsu_ok, 1);
    tick();
    @(negedge clk);
    check("contest_alu_second", bus.rel_rd, 3);
    check("contest_alu_ok_back", bus.alu_ok, 1);
    tick();

    // rd=0: released and counted but not written
    drive_alu(5'd0, 32'hFFFF, 1'b0, '0);
    expect_commit(5'd0, 32'hFFFF);
    @(negedge clk);
    check("contest_retired", bus.retired, 2);
    tick();
    idle_inputs();
    @(negedge clk);
    check("rd0_rf_we", bus.rf_we, 0);
    check("rd0_rel_valid", bus.rel_valid, 1);
    check("rd0_rel_rd", bus.rel_rd, 0);
    tick();

    // jump with an LSU entry left pending behind it
    drive_lsu(5'd9, 32'h99);
    expect_commit(5'd9, 32'h99);
    @(negedge clk);
    check("rd0_retired", bus.retired, 3);
    tick();
    idle_inputs();
    drive_alu(5'd1, 32'h8, 1'b1, 32'h0000_0101);
    drive_lsu(5'd10, 32'hAA);
    expect_commit(5'd1, 32'h8);
    @(negedge clk);
    check("jal_lsu_ok_while_commit", bus.lsu_ok, 1);
    tick();
    idle_inputs();
    @(negedge clk);
    check("jal_alu_wins", bus.rel_rd, 1);
    check("jal_lsu_pending_ok", bus.lsu_ok, 0);
    check("jal_no_flush_yet", bus.flush, 0);
    tick();
    drive_alu(5'd12, 32'hCC, 1'b0, '0);
    @(negedge clk);
    check("flush_flush", bus.flush, 1);
    check("flush_redirect_valid", bus.redirect_valid, 1);
    check("flush_redirect_pc", bus.redirect_pc, 32'h100);
    check("flush_alu_ok", bus.alu_ok, 0);
    check("flush_lsu_ok", bus.lsu_ok, 0);
    check("flush_rf_we", bus.rf_we, 0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("post_flush_flush", bus.flush, 0);
    check("post_flush_redirect_valid", bus.redirect_valid, 0);
    check("post_flush_redirect_pc_hold", bus.redirect_pc, 32'h100);
    check("post_flush_no_commit", bus.rel_valid, 0);
    check("jal_retired", bus.retired, 5);
    tick();

    // back-to-back ALU stream
    for (int i = 0; i < 8; i++) begin
      rd_r   = 5'($urandom_range(1, 31));
      data_r = $urandom;
      drive_alu(rd_r, data_r, 1'b0, '0);
      expect_commit(rd_r, data_r);
      @(negedge clk);
      check("stream_alu_ok", bus.alu_ok, 1);
      if (i > 0) check("stream_commit", bus.rel_valid, 1);
      tick();
    end
    idle_inputs();
    @(negedge clk);
    check("stream_last_commit", bus.rel_valid, 1);
    tick();
    @(negedge clk);
    check("stream_done", bus.rel_valid, 0);
    check("stream_retired", bus.retired, 13);
    tick();

    // reset with both entries full
    drive_alu(5'd2, 32'h22, 1'b0, '0);
    drive_lsu(5'd4, 32'h44);
    @(negedge clk);
    tick();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    check("midrst_alu_ok", bus.alu_ok, 0);
    check("midrst_lsu_ok", bus.lsu_ok, 0);
    check("midrst_rf_we", bus.rf_we, 0);
    check("midrst_rel_valid", bus.rel_valid, 0);
    tick();
    @(negedge clk);
    check("midrst_retired", bus.retired, 0);
    check("midrst_alu_ok2", bus.alu_ok, 0);
    tick();
    rst = 1'b0;
    drive_alu(5'd6, 32'h66, 1'b0, '0);
    expect_commit(5'd6, 32'h66);
    @(negedge clk);
    check("after_rst_alu_ok", bus.alu_ok, 1);
    tick();
    idle_inputs();
    @(negedge clk);
    check("after_rst_commit_rd", bus.rel_rd, 6);
    tick();
    @(negedge clk);
    check("after_rst_retired", bus.retired, 1);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
